stream_downsizer: RTL and testbench

STREAM_DOWNSIZER -- requirements
Module: stream_downsizer

---
 rtl/stream_downsizer.sv | 102 ++++++++++
 tb/tb_stream_downsizer.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/stream_downsizer.sv
// ============================================================================
//  Module   : stream_downsizer
//  Purpose  : Splits a wide input word into RATIO narrow output beats, emitting
//             only the valid beats and marking the packet end on the last one.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module stream_downsizer #(
    parameter int DATA_WIDTH = 8,
    parameter int RATIO      = 4
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [RATIO*DATA_WIDTH-1:0]   in_data,
    input  logic [$clog2(RATIO)-1:0]      in_beats,
    input  logic                          in_last,
    input  logic                          in_valid,
    output logic                          in_ready,
    output logic [DATA_WIDTH-1:0]         out_data,
    output logic                          out_last,
    output logic                          out_valid,
    input  logic                          out_ready
);

    localparam int BW = $clog2(RATIO);

    typedef enum logic [0:0] {
        S_EMPTY = 1'b0,
        S_DRAIN = 1'b1
    } state_t;

    state_t                        state_q, state_d;
    logic [BW-1:0]                 idx_q,   idx_d;
    logic [BW-1:0]                 max_q,   max_d;
    logic                          last_q,  last_d;
    logic [RATIO*DATA_WIDTH-1:0]   data_q,  data_d;

    logic                          last_beat;
    logic                          in_fire;
    logic                          out_fire;
    logic [DATA_WIDTH-1:0]         beat_sel [RATIO];

    // Held word viewed as an array of beats, beat 0 in the low bits.
    for (genvar g = 0; g < RATIO; g++) begin : g_beats
        assign beat_sel[g] = data_q[g*DATA_WIDTH +: DATA_WIDTH];
    end

    assign last_beat = (idx_q == max_q);
    assign out_valid = (state_q == S_DRAIN);
    assign out_data  = beat_sel[idx_q];
    assign out_last  = last_q && last_beat && out_valid;

    // A new word may enter on the same edge the final beat of the current one leaves.
    assign in_ready  = !reset && ((state_q == S_EMPTY) || (out_ready && last_beat));
    assign in_fire   = in_valid && in_ready;
    assign out_fire  = out_valid && out_ready;

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        max_d   = max_q;
        last_d  = last_q;
        data_d  = data_q;

        if (in_fire) begin
            state_d = S_DRAIN;
            idx_d   = '0;
            max_d   = in_beats;
            last_d  = in_last;
            data_d  = in_data;
        end else if (out_fire) begin
            if (last_beat) begin
                state_d = S_EMPTY;
            end else begin
                idx_d   = idx_q + BW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_EMPTY;
            idx_q   <= '0;
            max_q   <= '0;
            last_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            max_q   <= max_d;
            last_q  <= last_d;
        end
    end

    // Payload register carries no reset; it is only observed while out_valid is high.
    always_ff @(posedge clk) begin
        data_q <= data_d;
    end

endmodule

`default_nettype wire

// File: tb/tb_stream_downsizer.sv
// ============================================================================
//  Module   : tb_stream_downsizer
//  Purpose  : Directed bench for stream_downsizer (DATA_WIDTH=8, RATIO=4) with a
//             beat-queue reference model and per-cycle output comparison.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_stream_downsizer;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] in_data;
    logic [1:0]  in_beats;
    logic        in_last;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  out_data;
    logic        out_last;
    logic        out_valid;
    logic        out_ready;

    int passed = 0;
    int total  = 0;
    bit armed  = 1'b0;

    // Pending output beats {last, data} of the word currently held.
    logic [8:0] mq[$];
    // Beats actually handed to the sink, and what a scenario says they should be.
    logic [8:0] obs[$];
    logic [8:0] exp_log[$];

    stream_downsizer #(.DATA_WIDTH(8), .RATIO(4)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_data   (in_data),
        .in_beats  (in_beats),
        .in_last   (in_last),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_data  (out_data),
        .out_last  (out_last),
        .out_valid (out_valid),
        .out_ready (out_ready)
    );

    always #5 clk = ~clk;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            $display("FAIL %s: actual=%0h required=%0h", nm, act, exp);
        end else begin
            passed++;
        end
    endtask

    function automatic logic model_ready();
        return !reset && ((mq.size() == 0) || (out_ready && mq.size() == 1));
    endfunction

    // Reference model: a word turns into its list of beats; the sink pops them.
    always @(posedge clk) begin
        logic fire_in;
        logic fire_out;
        fire_in  = in_valid && model_ready();
        fire_out = (mq.size() > 0) && out_ready;
        if (reset) begin
            mq.delete();
        end else begin
            if (fire_out) void'(mq.pop_front());
            if (fire_in) begin
                for (int b = 0; b <= int'(in_beats); b++) begin
                    mq.push_back({in_last && (b == int'(in_beats)), in_data[b*8 +: 8]});
                end
            end
        end
    end

    always @(negedge clk) begin
        if (armed) begin
            logic exp_v;
            exp_v = (mq.size() > 0);
            check("cmp.out_valid", out_valid, exp_v);
            check("cmp.out_last", out_last, exp_v ? mq[0][8] : 1'b0);
            if (exp_v) check("cmp.out_data", out_data, mq[0][7:0]);
            check("cmp.in_ready", in_ready, model_ready());
            if (out_valid && out_ready) obs.push_back({out_last, out_data});
        end
    end

    // Checks outputs in the current cycle, then advances to just after the next edge.
    task automatic step(input string nm, input logic [7:0] d, input logic l,
                        input logic v, input logic r);
        #1;
        check({nm, ".out_valid"}, out_valid, v);
        check({nm, ".out_last"}, out_last, l);
        if (v) check({nm, ".out_data"}, out_data, d);
        check({nm, ".in_ready"}, in_ready, r);
        @(posedge clk);
        #1;
    endtask

    task automatic check_log(input string nm);
        check({nm, ".beat_count"}, obs.size(), exp_log.size());
        for (int i = 0; i < exp_log.size() && i < obs.size(); i++) begin
            check($sformatf("%s.beat%0d", nm, i), obs[i], exp_log[i]);
        end
        obs.delete();
    endtask

    task automatic offer(input logic [31:0] d, input logic [1:0] b, input logic l);
        in_data  = d;
        in_beats = b;
        in_last  = l;
        in_valid = 1'b1;
    endtask

    initial begin
        reset     = 1'b1;
        in_data   = '0;
        in_beats  = '0;
        in_last   = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        @(posedge clk);
        armed = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("reset.in_ready", in_ready, 1'b0);
        check("reset.out_valid", out_valid, 1'b0);
        check("reset.out_last", out_last, 1'b0);
        reset = 1'b0;
        out_ready = 1'b1;

        // Full word.
        offer(32'h44332211, 2'd3, 1'b1);
        step("s1.accept", 8'h00, 1'b0, 1'b0, 1'b1);
        in_valid = 1'b0;
        step("s1.b0", 8'h11, 1'b0, 1'b1, 1'b0);
        step("s1.b1", 8'h22, 1'b0, 1'b1, 1'b0);
        step("s1.b2", 8'h33, 1'b0, 1'b1, 1'b0);
        step("s1.b3", 8'h44, 1'b1, 1'b1, 1'b1);
        step("s1.idle", 8'h00, 1'b0, 1'b0, 1'b1);
        exp_log = '{9'h011, 9'h022, 9'h033, 9'h144};
        check_log("s1.log");

        // Back-to-back words, second accepted alongside beat 44.
        offer(32'h44332211, 2'd3, 1'b1);
        step("s2.accept", 8'h00, 1'b0, 1'b0, 1'b1);
        offer(32'h88776655, 2'd3, 1'b1);
        step("s2.b0", 8'h11, 1'b0, 1'b1, 1'b0);
        step("s2.b1", 8'h22, 1'b0, 1'b1, 1'b0);
        step("s2.b2", 8'h33, 1'b0, 1'b1, 1'b0);
        step("s2.b3", 8'h44, 1'b1, 1'b1, 1'b1);
        in_valid = 1'b0;
        step("s2.b4", 8'h55, 1'b0, 1'b1, 1'b0);
        step("s2.b5", 8'h66, 1'b0, 1'b1, 1'b0);
        step("s2.b6", 8'h77, 1'b0, 1'b1, 1'b0);
        step("s2.b7", 8'h88, 1'b1, 1'b1, 1'b1);
        step("s2.idle", 8'h00, 1'b0, 1'b0, 1'b1);
        exp_log = '{9'h011, 9'h022, 9'h033, 9'h144, 9'h055, 9'h066, 9'h077, 9'h188};
        check_log("s2.log");

        // Partial word: two beats only.
        offer(32'hDDCCBBAA, 2'd1, 1'b1);
        step("s3.accept", 8'h00, 1'b0, 1'b0, 1'b1);
        in_valid = 1'b0;
        step("s3.b0", 8'hAA, 1'b0, 1'b1, 1'b0);
        step("s3.b1", 8'hBB, 1'b1, 1'b1, 1'b1);
        step("s3.idle", 8'h00, 1'b0, 1'b0, 1'b1);
        exp_log = '{9'h0AA, 9'h1BB};
        check_log("s3.log");

        // Single-beat word.
        offer(32'h12345678, 2'd0, 1'b1);
        step("s7.accept", 8'h00, 1'b0, 1'b0, 1'b1);
        in_valid = 1'b0;
        step("s7.b0", 8'h78, 1'b1, 1'b1, 1'b1);
        step("s7.idle", 8'h00, 1'b0, 1'b0, 1'b1);
        exp_log = '{9'h178};
        check_log("s7.log");

        // Backpressure while beat 22 is presented.
        offer(32'h44332211, 2'd3, 1'b1);
        step("s4.accept", 8'h00, 1'b0, 1'b0, 1'b1);
        in_valid = 1'b0;
        step("s4.b0", 8'h11, 1'b0, 1'b1, 1'b0);
        out_ready = 1'b0;
        step("s4.hold0", 8'h22, 1'b0, 1'b1, 1'b0);
        step("s4.hold1", 8'h22, 1'b0, 1'b1, 1'b0);
        step("s4.hold2", 8'h22, 1'b0, 1'b1, 1'b0);
        out_ready = 1'b1;
        step("s4.b1", 8'h22, 1'b0, 1'b1, 1'b0);
        step("s4.b2", 8'h33, 1'b0, 1'b1, 1'b0);
        out_ready = 1'b0;
        step("s4.hold3", 8'h44, 1'b1, 1'b1, 1'b0);
        out_ready = 1'b1;
        step("s4.b3", 8'h44, 1'b1, 1'b1, 1'b1);
        step("s4.idle", 8'h00, 1'b0, 1'b0, 1'b1);
        exp_log = '{9'h011, 9'h022, 9'h033, 9'h144};
        check_log("s4.log");

        // Reset in the middle of a word discards the remaining beats.
        offer(32'h44332211, 2'd3, 1'b1);
        step("s5.accept", 8'h00, 1'b0, 1'b0, 1'b1);
        in_valid = 1'b0;
        step("s5.b0", 8'h11, 1'b0, 1'b1, 1'b0);
        step("s5.b1", 8'h22, 1'b0, 1'b1, 1'b0);
        reset = 1'b1;
        out_ready = 1'b0;
        step("s5.rst", 8'h33, 1'b0, 1'b1, 1'b0);
        reset = 1'b0;
        out_ready = 1'b1;
        step("s5.post0", 8'h00, 1'b0, 1'b0, 1'b1);
        step("s5.post1", 8'h00, 1'b0, 1'b0, 1'b1);
        exp_log = '{9'h011, 9'h022};
        check_log("s5.log");

        // Non-final word never marks a packet end.
        offer(32'hA1B2C3D4, 2'd3, 1'b0);
        step("s6.accept", 8'h00, 1'b0, 1'b0, 1'b1);
        in_valid = 1'b0;
        step("s6.b0", 8'hD4, 1'b0, 1'b1, 1'b0);
        step("s6.b1", 8'hC3, 1'b0, 1'b1, 1'b0);
        step("s6.b2", 8'hB2, 1'b0, 1'b1, 1'b0);
        step("s6.b3", 8'hA1, 1'b0, 1'b1, 1'b1);
        step("s6.idle", 8'h00, 1'b0, 1'b0, 1'b1);
        exp_log = '{9'h0D4, 9'h0C3, 9'h0B2, 9'h0A1};
        check_log("s6.log");

        @(negedge clk);
        armed = 1'b0;
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

`default_nettype wire
